mem_sram_controller: RTL and testbench

- Multi-cycle controller between the ARM pipeline MEM stage and an external 16-bit asynchronous SRAM.
- Accepts 32-bit word read/write requests from the MEM stage. Translates the byte address as (address - BASE_ADDR) >> 2.
- Sequences two 16-bit SRAM accesses per word, low half first.
- Deasserts ready while busy. The hazard/pipeline logic uses ~ready as the global freeze.

---
 rtl/mem_sram_controller_if.sv | 21 ++
 rtl/mem_sram_controller.sv | 128 ++++++++++++
 tb/tb_mem_sram_controller.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sram_controller_if.sv
// MEM-stage request/response bus between the pipeline and the SRAM controller.
interface mem_sram_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  // Pipeline side: issues word requests, freezes on ~ready.
  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  // Controller side.
  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/mem_sram_controller.sv
// Multi-cycle bridge from 32-bit MEM-stage word accesses to a 16-bit asynchronous SRAM.
// Each word is split into two half-word accesses (low half first), each held WAIT_CYCLES.
module mem_sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_sram_controller_if.slave bus,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [15:0]          sram_dq_out,
  input  logic [15:0]          sram_dq_in,
  output logic                 sram_dq_oe,
  output logic                 sram_we_n
);

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            op_wr_q, op_wr_d;
  logic [29:0]     word_addr_q, word_addr_d;
  logic [31:0]     data_q, data_d;
  logic [31:0]     read_data_q, read_data_d;
  logic            last;

  assign last          = (cnt_q == CntLast);
  assign bus.read_data = read_data_q;

  // State and latched-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      word_addr_q <= '0;
      data_q      <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      word_addr_q <= word_addr_d;
      data_q      <= data_d;
      read_data_q <= read_data_d;
    end
  end

  // Next-state logic, request latching, read capture and the pipeline ready.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    word_addr_d = word_addr_q;
    data_d      = data_q;
    read_data_d = read_data_q;
    bus.ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.ready = ~(bus.rd_en | bus.wr_en);
        if (bus.rd_en | bus.wr_en) begin
          // A simultaneous read and write is treated as a write.
          op_wr_d     = bus.wr_en;
          word_addr_d = 30'((bus.address - 32'(BASE_ADDR)) >> 2);
          data_d      = bus.write_data;
          cnt_d       = '0;
          state_d     = StLow;
        end
      end
      StLow: begin
        if (last) begin
          if (!op_wr_q) read_data_d[15:0] = sram_dq_in;
          cnt_d   = '0;
          state_d = StHigh;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHigh: begin
        if (last) begin
          if (!op_wr_q) read_data_d[31:16] = sram_dq_in;
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        bus.ready = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // SRAM pins decode from registers only; we_n rises on the last cycle so that
  // address and data stay stable across its rising edge.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    unique case (state_q)
      StLow: begin
        sram_addr = SRAM_AW'({word_addr_q, 1'b0});
        if (op_wr_q) begin
          sram_dq_out = data_q[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = last;
        end
      end
      StHigh: begin
        sram_addr = SRAM_AW'({word_addr_q, 1'b1});
        if (op_wr_q) begin
          sram_dq_out = data_q[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = last;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_sram_controller.sv
// Directed bench: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=1 instance, each on a small SRAM model.
module tb_mem_sram_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_sram_controller_if m2 ();
  mem_sram_controller_if m1 ();

  logic [17:0] a2, a1;
  logic [15:0] dqo2, dqi2, dqo1, dqi1;
  logic        oe2, we2, oe1, we1;

  mem_sram_controller #(.BASE_ADDR(1024), .SRAM_AW(18), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .bus(m2),
    .sram_addr(a2), .sram_dq_out(dqo2), .sram_dq_in(dqi2), .sram_dq_oe(oe2), .sram_we_n(we2)
  );

  mem_sram_controller #(.BASE_ADDR(1024), .SRAM_AW(18), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(m1),
    .sram_addr(a1), .sram_dq_out(dqo1), .sram_dq_in(dqi1), .sram_dq_oe(oe1), .sram_we_n(we1)
  );

  // SRAM models: write while we_n is low, read combinationally.
  logic [15:0] mem2 [64];
  logic [15:0] mem1 [64];
  logic        mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem2[i] <= 16'h0000;
        mem1[i] <= 16'h1000 + 16'(i);
      end
    end else begin
      if (!we2 && oe2) mem2[a2[5:0]] <= dqo2;
      if (!we1 && oe1) mem1[a1[5:0]] <= dqo1;
    end
  end

  assign dqi2 = mem2[a2[5:0]];
  assign dqi1 = mem1[a1[5:0]];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-cycle trace of one WAIT_CYCLES=2 transaction; index 0 is the IDLE cycle.
  logic [17:0] tr_addr [8];
  logic [15:0] tr_dq   [8];
  logic        tr_we   [8];
  logic        tr_oe   [8];
  int          n2;

  // Issue a request on m2 and hold it until ready; returns positioned in DONE.
  task automatic run2(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    m2.rd_en      = rd;
    m2.wr_en      = wr;
    m2.address    = a;
    m2.write_data = d;
    n2 = 0;
    #1;
    while (!m2.ready && n2 < 20) begin
      if (n2 < 8) begin
        tr_addr[n2] = a2;
        tr_dq[n2]   = dqo2;
        tr_we[n2]   = we2;
        tr_oe[n2]   = oe2;
      end
      n2++;
      @(posedge clk);
      #1;
    end
    m2.rd_en = 1'b0;
    m2.wr_en = 1'b0;
  endtask

  int n1;

  initial begin
    rst = 1'b1;
    mem_init = 1'b1;
    m2.rd_en = 1'b0; m2.wr_en = 1'b0; m2.address = '0; m2.write_data = '0;
    m1.rd_en = 1'b0; m1.wr_en = 1'b0; m1.address = '0; m1.write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    rst = 1'b0;

    // Idle after reset.
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ready", 32'(m2.ready), 32'd1);
    chk("idle_we_n", 32'(we2), 32'd1);
    chk("idle_oe", 32'(oe2), 32'd0);
    chk("idle_rdata", m2.read_data, 32'h0);
    chk("idle_addr", 32'(a2), 32'd0);
    chk("idle_dq", 32'(dqo2), 32'd0);

    // Write 0xDEADBEEF to 1024.
    run2(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    chk("wr_frozen", n2, 5);
    chk("wr_done_ready", 32'(m2.ready), 32'd1);
    chk("wr_idle_we", 32'(tr_we[0]), 32'd1);
    chk("wr_lo_addr", 32'(tr_addr[1]), 32'd0);
    chk("wr_lo_dq", 32'(tr_dq[1]), 32'hBEEF);
    chk("wr_lo_oe", 32'(tr_oe[1]), 32'd1);
    chk("wr_lo_we0", 32'(tr_we[1]), 32'd0);
    chk("wr_lo_we1", 32'(tr_we[2]), 32'd1);
    chk("wr_lo_addr2", 32'(tr_addr[2]), 32'd0);
    chk("wr_hi_addr", 32'(tr_addr[3]), 32'd1);
    chk("wr_hi_dq", 32'(tr_dq[3]), 32'hDEAD);
    chk("wr_hi_we0", 32'(tr_we[3]), 32'd0);
    chk("wr_hi_we1", 32'(tr_we[4]), 32'd1);
    chk("wr_rdata_kept", m2.read_data, 32'h0);
    @(posedge clk);
    #1;
    chk("wr_after_ready", 32'(m2.ready), 32'd1);
    chk("wr_after_we", 32'(we2), 32'd1);
    chk("wr_mem0", 32'(mem2[0]), 32'hBEEF);
    chk("wr_mem1", 32'(mem2[1]), 32'hDEAD);

    // Read back 1024.
    run2(1'b1, 1'b0, 32'd1024, 32'h0);
    chk("rd_frozen", n2, 5);
    chk("rd_oe", 32'(tr_oe[1]), 32'd0);
    chk("rd_we", 32'(tr_we[1]), 32'd1);
    chk("rd_data", m2.read_data, 32'hDEADBEEF);
    @(posedge clk);
    #1;

    // Write then read 1032 (half-words 4/5).
    run2(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    run2(1'b1, 1'b0, 32'd1032, 32'h0);
    chk("rd2_lo_addr", 32'(tr_addr[1]), 32'd4);
    chk("rd2_hi_addr", 32'(tr_addr[3]), 32'd5);
    chk("rd2_data", m2.read_data, 32'hCAFEF00D);
    @(posedge clk);
    #1;

    // Read and write together: write wins, read_data untouched.
    run2(1'b1, 1'b1, 32'd1028, 32'h12345678);
    chk("both_lo_addr", 32'(tr_addr[1]), 32'd2);
    chk("both_hi_addr", 32'(tr_addr[3]), 32'd3);
    chk("both_oe", 32'(tr_oe[1]), 32'd1);
    chk("both_rdata", m2.read_data, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    chk("both_mem2", 32'(mem2[2]), 32'h5678);
    chk("both_mem3", 32'(mem2[3]), 32'h1234);

    // WAIT_CYCLES=1: back-to-back reads of 1024 and 1028.
    m1.rd_en   = 1'b1;
    m1.address = 32'd1024;
    #1;
    n1 = 0;
    while (!m1.ready && n1 < 20) begin
      n1++;
      @(posedge clk);
      #1;
    end
    chk("w1_frozen_a", n1, 3);
    chk("w1_data_a", m1.read_data, 32'h10011000);
    m1.address = 32'd1028;
    @(posedge clk);
    #1;
    chk("w1_idle_gap", 32'(m1.ready), 32'd0);
    n1 = 0;
    while (!m1.ready && n1 < 20) begin
      n1++;
      @(posedge clk);
      #1;
    end
    chk("w1_frozen_b", n1, 3);
    chk("w1_data_b", m1.read_data, 32'h10031002);
    m1.rd_en = 1'b0;
    @(posedge clk);
    #1;

    // Reset during the HIGH half of a write to 1036 (half-words 6/7).
    m2.wr_en      = 1'b1;
    m2.address    = 32'd1036;
    m2.write_data = 32'hAABBCCDD;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_high", 32'(a2), 32'd7);
    rst = 1'b1;
    m2.wr_en = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(m2.ready), 32'd1);
    chk("rst_we", 32'(we2), 32'd1);
    chk("rst_oe", 32'(oe2), 32'd0);
    chk("rst_addr", 32'(a2), 32'd0);
    chk("rst_dq", 32'(dqo2), 32'd0);
    chk("rst_rdata", m2.read_data, 32'h0);
    rst = 1'b0;
    chk("rst_mem6", 32'(mem2[6]), 32'hCCDD);
    chk("rst_mem7", 32'(mem2[7]), 32'h0000);
    @(posedge clk);
    #1;
    run2(1'b1, 1'b0, 32'd1036, 32'h0);
    chk("rst_readback", m2.read_data, 32'h0000CCDD);
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
